ysyx_22050612_mem_arbiter: RTL

Two-master memory arbiter/sequencer placed between the instruction fetch unit (IFU), the load/store unit (LSU) and the single shared memory port (DPI `pmem_read`/`pmem_write` wrapper) of the multi-cycle ysyx_22050612 core. It accepts one request at a time, gives the LSU fixed priority over the IFU, and drives the memory port through a request/response handshake. It routes the response back to the owning master. It holds at most one transaction in flight.

---
 rtl/ysyx_22050612_mem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter for the single shared memory port.
// LSU has fixed priority; one transaction in flight; responses return to the owning master.
module ysyx_22050612_mem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // instruction fetch master
  input  logic                ifu_req_valid_i,
  output logic                ifu_req_ready_o,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_resp_valid_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  // load/store master
  input  logic                lsu_req_valid_i,
  output logic                lsu_req_ready_o,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic                lsu_wen_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wmask_i,
  output logic                lsu_resp_valid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  // shared memory port
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_wen_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_resp_valid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_wen_q, mem_wen_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                ifu_resp_q, ifu_resp_d;
  logic                lsu_resp_q, lsu_resp_d;

  // Acceptance only in IDLE and outside reset; LSU masks the IFU.
  always_comb begin
    lsu_req_ready_o = (state_q == S_IDLE) && !rst_i;
    ifu_req_ready_o = (state_q == S_IDLE) && !rst_i && !lsu_req_valid_i;
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    ifu_resp_d  = 1'b0;
    lsu_resp_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (lsu_req_valid_i && lsu_req_ready_o) begin
          mem_addr_d  = lsu_addr_i;
          mem_wen_d   = lsu_wen_i;
          mem_wdata_d = lsu_wdata_i;
          mem_wmask_d = lsu_wmask_i;
          owner_d     = OWNER_LSU;
          state_d     = S_REQ;
        end else if (ifu_req_valid_i && ifu_req_ready_o) begin
          mem_addr_d  = ifu_addr_i;
          mem_wen_d   = 1'b0;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
          owner_d     = OWNER_IFU;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid_i) begin
          if (owner_q == OWNER_LSU) begin
            lsu_rdata_d = mem_rdata_i;
            lsu_resp_d  = 1'b1;
          end else begin
            ifu_rdata_d = mem_rdata_i;
            ifu_resp_d  = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset also drops any pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= OWNER_IFU;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      ifu_resp_q  <= ifu_resp_d;
      lsu_resp_q  <= lsu_resp_d;
    end
  end

  assign mem_req_valid_o  = (state_q == S_REQ);
  assign mem_addr_o       = mem_addr_q;
  assign mem_wen_o        = mem_wen_q;
  assign mem_wdata_o      = mem_wdata_q;
  assign mem_wmask_o      = mem_wmask_q;
  assign ifu_rdata_o      = ifu_rdata_q;
  assign lsu_rdata_o      = lsu_rdata_q;
  assign ifu_resp_valid_o = ifu_resp_q;
  assign lsu_resp_valid_o = lsu_resp_q;

endmodule
